// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with a registered divided clock,
// a period-start tick, and ratio changes deferred to period boundaries.
module prog_clk_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             div_pending
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_CNT = (DEFAULT_DIV == 0) ? '0 : WIDTH'(DEFAULT_DIV - 1);
  localparam logic [WIDTH:0]   ONE_W1  = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic             stopped;
  logic             boundary;
  logic [WIDTH-1:0] div_commit;
  logic [WIDTH:0]   half;

  assign stopped    = (div_cur_q == '0);
  assign boundary   = en && !stopped && (cnt_q == (div_cur_q - ONE));
  assign div_commit = div_load ? div_val : (pend_q ? pend_val_q : div_cur_q);

  // High-phase length for the ratio in effect after this edge, one bit wider
  // so the maximum ratio does not wrap to zero.
  assign half = ({1'b0, div_cur_d} + ONE_W1) >> 1;

  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;

    if (stopped) begin
      // A stopped divider accepts a load directly, primed to start a period
      // on the next enabled edge.
      clk_out_d = 1'b0;
      cnt_d     = '0;
      if (div_load) begin
        div_cur_d = div_val;
        cnt_d     = (div_val == '0) ? '0 : (div_val - ONE);
        pend_d    = 1'b0;
      end
    end else begin
      if (boundary) begin
        div_cur_d = div_commit;
        pend_d    = 1'b0;
        cnt_d     = '0;
      end else if (div_load) begin
        pend_val_d = div_val;
        pend_d     = 1'b1;
      end

      if (en) begin
        if (!boundary) begin
          cnt_d = cnt_q + ONE;
        end
        clk_out_d = ({1'b0, cnt_d} < half);
        tick_d    = (cnt_d == '0) && (div_cur_d != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= DEF_CNT;
      div_cur_q  <= DEF_DIV;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign div_active  = div_cur_q;
  assign div_pending = pend_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: per-scenario tables of stimulus and
// hand-computed {clk_out, tick, div_active, div_pending} after each edge.
module tb_prog_clk_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       div_load;
  logic [7:0] div_val;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_active;
  logic       div_pending;

  int vec_cnt = 0;
  int err_cnt = 0;

  prog_clk_divider #(
    .WIDTH      (8),
    .DEFAULT_DIV(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .div_load   (div_load),
    .div_val    (div_val),
    .clk_out    (clk_out),
    .tick       (tick),
    .div_active (div_active),
    .div_pending(div_pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = 8'd0;
  end

  // driver helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // stimulus word: {reset, en, div_load, div_val}
  function automatic logic [10:0] s(input int r, input int e, input int l, input int v);
    logic [31:0] rr, ee, ll, vv;
    rr = r; ee = e; ll = l; vv = v;
    return {rr[0], ee[0], ll[0], vv[7:0]};
  endfunction

  // expected word: {clk_out, tick, div_active, div_pending}
  function automatic logic [10:0] x(input int c, input int t, input int a, input int p);
    logic [31:0] cc, tt, aa, pp;
    cc = c; tt = t; aa = a; pp = p;
    return {cc[0], tt[0], aa[7:0], pp[0]};
  endfunction

  task automatic test_reset();
    logic [10:0] st [2];
    logic [10:0] ex [2];
    logic [10:0] got;
    st = '{s(1,1,1,9), s(0,0,0,0)};
    ex = '{x(0,0,4,0), x(0,0,4,0)};
    for (int i = 0; i < 2; i++) begin
      {reset, en, div_load, div_val} = st[i];
      cyc();
      got = {clk_out, tick, div_active, div_pending};
      vec_cnt++;
      if (got !== ex[i]) begin
        err_cnt++;
        $display("FAIL reset step %0d: got clk_out=%b tick=%b active=%0d pend=%b, want %b %b %0d %b",
                 i, got[10], got[9], got[8:1], got[0], ex[i][10], ex[i][9], ex[i][8:1], ex[i][0]);
      end
    end
  endtask

  task automatic test_default();
    logic [10:0] ex [8];
    logic [10:0] got;
    ex = '{x(1,1,4,0), x(1,0,4,0), x(0,0,4,0), x(0,0,4,0),
           x(1,1,4,0), x(1,0,4,0), x(0,0,4,0), x(0,0,4,0)};
    for (int i = 0; i < 8; i++) begin
      {reset, en, div_load, div_val} = s(0,1,0,0);
      cyc();
      got = {clk_out, tick, div_active, div_pending};
      vec_cnt++;
      if (got !== ex[i]) begin
        err_cnt++;
        $display("FAIL default step %0d: got clk_out=%b tick=%b active=%0d pend=%b, want %b %b %0d %b",
                 i, got[10], got[9], got[8:1], got[0], ex[i][10], ex[i][9], ex[i][8:1], ex[i][0]);
      end
    end
  endtask

  task automatic test_ratio_change();
    logic [10:0] st [10];
    logic [10:0] ex [10];
    logic [10:0] got;
    st = '{s(0,1,0,0), s(0,1,1,5), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0),
           s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0)};
    ex = '{x(1,1,4,0), x(1,0,4,1), x(0,0,4,1), x(0,0,4,1), x(1,1,5,0),
           x(1,0,5,0), x(1,0,5,0), x(0,0,5,0), x(0,0,5,0), x(1,1,5,0)};
    for (int i = 0; i < 10; i++) begin
      {reset, en, div_load, div_val} = st[i];
      cyc();
      got = {clk_out, tick, div_active, div_pending};
      vec_cnt++;
      if (got !== ex[i]) begin
        err_cnt++;
        $display("FAIL ratio_change step %0d: got clk_out=%b tick=%b active=%0d pend=%b, want %b %b %0d %b",
                 i, got[10], got[9], got[8:1], got[0], ex[i][10], ex[i][9], ex[i][8:1], ex[i][0]);
      end
    end
  endtask

  task automatic test_last_wins();
    logic [10:0] st [14];
    logic [10:0] ex [14];
    logic [10:0] got;
    st = '{s(0,1,1,3), s(0,1,1,6), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0),
           s(0,1,0,0), s(0,1,0,0), s(0,1,1,7), s(0,1,0,0), s(0,1,0,0),
           s(0,1,1,2), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0)};
    ex = '{x(1,0,5,1), x(1,0,5,1), x(0,0,5,1), x(0,0,5,1), x(1,1,6,0),
           x(1,0,6,0), x(1,0,6,0), x(0,0,6,1), x(0,0,6,1), x(0,0,6,1),
           x(1,1,2,0), x(0,0,2,0), x(1,1,2,0), x(0,0,2,0)};
    for (int i = 0; i < 14; i++) begin
      {reset, en, div_load, div_val} = st[i];
      cyc();
      got = {clk_out, tick, div_active, div_pending};
      vec_cnt++;
      if (got !== ex[i]) begin
        err_cnt++;
        $display("FAIL last_wins step %0d: got clk_out=%b tick=%b active=%0d pend=%b, want %b %b %0d %b",
                 i, got[10], got[9], got[8:1], got[0], ex[i][10], ex[i][9], ex[i][8:1], ex[i][0]);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [10:0] st [8];
    logic [10:0] ex [8];
    logic [10:0] got;
    st = '{s(0,1,1,4), s(0,0,0,0), s(0,0,1,4), s(0,0,0,0),
           s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0)};
    ex = '{x(1,1,4,0), x(1,0,4,0), x(1,0,4,1), x(1,0,4,1),
           x(1,0,4,1), x(0,0,4,1), x(0,0,4,1), x(1,1,4,0)};
    for (int i = 0; i < 8; i++) begin
      {reset, en, div_load, div_val} = st[i];
      cyc();
      got = {clk_out, tick, div_active, div_pending};
      vec_cnt++;
      if (got !== ex[i]) begin
        err_cnt++;
        $display("FAIL enable_hold step %0d: got clk_out=%b tick=%b active=%0d pend=%b, want %b %b %0d %b",
                 i, got[10], got[9], got[8:1], got[0], ex[i][10], ex[i][9], ex[i][8:1], ex[i][0]);
      end
    end
  endtask

  task automatic test_special_ratios();
    logic [10:0] st [14];
    logic [10:0] ex [14];
    logic [10:0] got;
    st = '{s(0,1,1,1), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0),
           s(0,1,0,0), s(0,1,1,0), s(0,1,0,0), s(0,1,0,0), s(0,0,1,2),
           s(0,0,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0)};
    ex = '{x(1,0,4,1), x(0,0,4,1), x(0,0,4,1), x(1,1,1,0), x(1,1,1,0),
           x(1,1,1,0), x(0,0,0,0), x(0,0,0,0), x(0,0,0,0), x(0,0,2,0),
           x(0,0,2,0), x(1,1,2,0), x(0,0,2,0), x(1,1,2,0)};
    for (int i = 0; i < 14; i++) begin
      {reset, en, div_load, div_val} = st[i];
      cyc();
      got = {clk_out, tick, div_active, div_pending};
      vec_cnt++;
      if (got !== ex[i]) begin
        err_cnt++;
        $display("FAIL special_ratios step %0d: got clk_out=%b tick=%b active=%0d pend=%b, want %b %b %0d %b",
                 i, got[10], got[9], got[8:1], got[0], ex[i][10], ex[i][9], ex[i][8:1], ex[i][0]);
      end
    end
  endtask

  task automatic test_max_ratio();
    logic [10:0] st [2];
    logic [10:0] ex [2];
    logic [10:0] got;
    logic [10:0] exp_end;
    int high_cnt;
    int tick_cnt;
    int edge_cnt;
    logic prev_clk;
    st = '{s(0,1,1,255), s(0,1,0,0)};
    ex = '{x(0,0,2,1), x(1,1,255,0)};
    for (int i = 0; i < 2; i++) begin
      {reset, en, div_load, div_val} = st[i];
      cyc();
      got = {clk_out, tick, div_active, div_pending};
      vec_cnt++;
      if (got !== ex[i]) begin
        err_cnt++;
        $display("FAIL max_ratio step %0d: got clk_out=%b tick=%b active=%0d pend=%b, want %b %b %0d %b",
                 i, got[10], got[9], got[8:1], got[0], ex[i][10], ex[i][9], ex[i][8:1], ex[i][0]);
      end
    end
    // rest of the 255-cycle period: 127 more high cycles, one fall, no tick
    high_cnt = 0;
    tick_cnt = 0;
    edge_cnt = 0;
    prev_clk = clk_out;
    for (int i = 0; i < 254; i++) begin
      cyc();
      if (clk_out === 1'b1) high_cnt++;
      if (tick === 1'b1) tick_cnt++;
      if (clk_out !== prev_clk) edge_cnt++;
      prev_clk = clk_out;
    end
    vec_cnt++;
    if (high_cnt != 127) begin
      err_cnt++;
      $display("FAIL max_ratio high_cycles: got %0d, want 127", high_cnt);
    end
    vec_cnt++;
    if (tick_cnt != 0 || edge_cnt != 1) begin
      err_cnt++;
      $display("FAIL max_ratio ticks/edges: got ticks=%0d edges=%0d, want 0 1", tick_cnt, edge_cnt);
    end
    cyc();
    exp_end = x(1,1,255,0);
    got = {clk_out, tick, div_active, div_pending};
    vec_cnt++;
    if (got !== exp_end) begin
      err_cnt++;
      $display("FAIL max_ratio wrap: got clk_out=%b tick=%b active=%0d pend=%b, want 1 1 255 0",
               got[10], got[9], got[8:1], got[0]);
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] st [11];
    logic [10:0] ex [11];
    logic [10:0] got;
    st = '{s(0,1,1,9), s(0,1,0,0), s(1,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0),
           s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0), s(0,1,0,0)};
    ex = '{x(1,0,255,1), x(1,0,255,1), x(0,0,4,0), x(1,1,4,0), x(1,0,4,0), x(0,0,4,0),
           x(0,0,4,0), x(1,1,4,0), x(1,0,4,0), x(0,0,4,0), x(0,0,4,0)};
    for (int i = 0; i < 11; i++) begin
      {reset, en, div_load, div_val} = st[i];
      cyc();
      got = {clk_out, tick, div_active, div_pending};
      vec_cnt++;
      if (got !== ex[i]) begin
        err_cnt++;
        $display("FAIL mid_reset step %0d: got clk_out=%b tick=%b active=%0d pend=%b, want %b %b %0d %b",
                 i, got[10], got[9], got[8:1], got[0], ex[i][10], ex[i][9], ex[i][8:1], ex[i][0]);
      end
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_default();
    test_ratio_change();
    test_last_wins();
    test_enable_hold();
    test_special_ratios();
    test_max_ratio();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
